// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default sizes, overflow state
// encoding and Gray/binary pointer conversions used by both domains.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 5;
    localparam int FIFO_DATASIZE = 8;

    typedef enum logic {
        OVF_OK  = 1'b0,
        OVF_ERR = 1'b1
    } ovf_state_e;

    // Width-agnostic: callers zero-extend and cast the result back.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Producer/fifomem side bundle of the write-pointer controller.
// wafull exists only when WPTR_AFULL_EN is defined.
interface wptr_full_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE
);

    logic                winc;
    logic                wovf_clr;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic                wfull;
    logic [ADDRSIZE:0]   wfill;
    logic                wovf;
`ifdef WPTR_AFULL_EN
    logic                wafull;
`endif

    modport master (
`ifdef WPTR_AFULL_EN
        input  wafull,
`endif
        output winc,
        output wovf_clr,
        input  wclken,
        input  waddr,
        input  wfull,
        input  wfill,
        input  wovf
    );

    modport slave (
`ifdef WPTR_AFULL_EN
        output wafull,
`endif
        input  winc,
        input  wovf_clr,
        output wclken,
        output waddr,
        output wfull,
        output wfill,
        output wovf
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q, q1_d;
    logic [WIDTH-1:0] q2_q, q2_d;

    always_comb begin
        q1_d = d;
        q2_d = q1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full, fill-level and overflow control of the async FIFO.
// Define WPTR_AFULL_EN to add the registered almost-full output wafull.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = FIFO_ADDRSIZE
`ifdef WPTR_AFULL_EN
    , parameter int AFULL_LEVEL = 28
`endif
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic [ADDRSIZE:0] rptr_gray,
    output logic [ADDRSIZE:0] wptr,
    wptr_full_ctrl_if.slave   bus
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wfill_q, wfill_d;
    logic          wfull_q, wfull_d;
    ovf_state_e    ovf_q, ovf_d;

    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] full_ptr;
    logic          winc_ok;

    sync_2ff #(
        .WIDTH(PW)
    ) u_rptr_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr_gray),
        .q  (wq2_rptr)
    );

    always_comb begin
        winc_ok   = bus.winc & ~wfull_q;
        wbin_d    = wbin_q + PW'(winc_ok);
        wptr_d    = PW'(bin2gray(32'(wbin_d)));
        rbin_sync = PW'(gray2bin(32'(wq2_rptr)));
        // Full: next write pointer is one lap ahead of the read pointer.
        full_ptr  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                     wq2_rptr[ADDRSIZE-2:0]};
        wfull_d   = (wptr_d == full_ptr);
        wfill_d   = wbin_d - rbin_sync;
    end

    // A refused write outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        unique case (ovf_q)
            OVF_OK: begin
                if (bus.winc & wfull_q) ovf_d = OVF_ERR;
            end
            OVF_ERR: begin
                if (!(bus.winc & wfull_q) && bus.wovf_clr) ovf_d = OVF_OK;
            end
            default: ovf_d = OVF_OK;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wfill_q <= '0;
            ovf_q   <= OVF_OK;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wptr_d;
            wfull_q <= wfull_d;
            wfill_q <= wfill_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef WPTR_AFULL_EN
    localparam logic [PW-1:0] AFL = PW'(AFULL_LEVEL);

    logic wafull_q, wafull_d;

    always_comb begin
        wafull_d = (wfill_d >= AFL);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign bus.wafull = wafull_q;
`endif

    assign bus.wclken = winc_ok;
    assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
    assign bus.wfull  = wfull_q;
    assign bus.wfill  = wfill_q;
    assign bus.wovf   = (ovf_q == OVF_ERR);
    assign wptr       = wptr_q;

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-side controller for the dual-clock FIFO. It sits directly upstream of fifomem and drives its wclken, waddr and wfull.
- Keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer into wclk.
- Produces a registered full flag, a fill level and a sticky overflow error for the write-side producer.

Parameters:
- ADDRSIZE, 5, address width of fifomem. Depth = 2^ADDRSIZE. Legal range ≥ 2.
- AFULL_LEVEL, 28, fill level at or above which wafull asserts. Used only with the optional feature. Must be < 2^ADDRSIZE.

Ports:
- wclk  in  1  write-domain clock; all state updates on posedge.
- wrst  in  1  synchronous, active-high reset.
- winc  in  1  producer write request for the current cycle.
- rptr_gray  in  ADDRSIZE+1  read-domain Gray pointer, asynchronous to wclk.
- wovf_clr  in  1  clears the sticky overflow flag.
- wclken  out  1  write enable to fifomem; combinational, = winc & ~wfull.
- waddr  out  ADDRSIZE  write address to fifomem; = wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- wfull  out  1  registered full flag; also wired to fifomem wfull.
- wfill  out  ADDRSIZE+1  registered occupancy as seen from the write side, 0..2^ADDRSIZE.
- wovf  out  1  sticky overflow: set when winc is asserted while wfull=1.
- wafull  out  1  almost-full; present only with WPTR_AFULL_EN.

Behaviour:
- Reset: wclk and wrst (synchronous, active-high) are already decided.
  - On a posedge with wrst=1, clear wbin, wptr, wq1_rptr, wq2_rptr, wfull, wfill, wovf and wafull to 0.
  - wrst has priority over every other input.
  - Reset mid-operation discards all pointer state. The read side must be reset in the same window.
- Synchroniser: two flops, rptr_gray → wq1_rptr → wq2_rptr, no logic between them. Latency from a read-side pointer change to wq2_rptr is 2 wclk edges.
- Pointer update:
  - winc_ok = winc & ~wfull.
  - wbinnext = wbin + winc_ok, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - On posedge: wbin ← wbinnext, wptr ← wgraynext.
- Memory timing:
  - fifomem captures on negedge wclk. waddr and wclken therefore reflect the pre-increment pointer for the whole cycle.
  - The write lands at the negedge; the pointer advances at the following posedge.
  - wdata routes producer → fifomem directly and is not registered here.
- Full:
  - wfull ← (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Registered, so it asserts on the same edge that stores the last slot.
  - Deassertion is pessimistic: it happens at least 2 wclk after the read pointer moves.
- Fill level:
  - rbin_sync = Gray-to-binary of wq2_rptr.
  - wfill ← (wbinnext − rbin_sync) mod 2^(ADDRSIZE+1), registered.
  - Never exceeds 2^ADDRSIZE. Equals 2^ADDRSIZE exactly when wfull=1.
- Overflow sub-FSM, two states:
  - OK → ERR when winc=1 & wfull=1. The write is dropped and the pointer holds.
  - ERR → OK when wovf_clr=1.
  - If set and clear occur in the same cycle, set wins and the state stays ERR.
  - wovf = (state == ERR).
- Wrap-around: the extra MSB of wbin toggles every 2^ADDRSIZE writes. The Gray comparison distinguishes full from empty.
- Simultaneous write and read when full: the write is refused this cycle. The freed slot becomes visible after synchronisation.

Optional Feature:
- WPTR_AFULL_EN defined: register wafull ← (wfill_next ≥ AFULL_LEVEL), same timing as wfill.
- Undefined: the wafull port and its logic are absent, and AFULL_LEVEL is unused.

Decomposition:
- Package fifo_pkg:
  - ADDRSIZE and DATASIZE defaults.
  - Overflow state encoding (OK=1'b0, ERR=1'b1).
  - Gray↔binary conversion functions, shared with the read-side controller.
- One sub-module, sync_2ff (parameterised width, wclk, wrst), reused in the read domain for wptr.

Test Plan:
(ADDRSIZE=5, asynchronous rclk at 0.7× wclk, read side modelled by the bench)
1. Reset: hold wrst for 3 cycles with winc=1 → wptr=0, waddr=0, wfull=0, wfill=0, wovf=0, and no wclken during reset-cleared state.
2. Fill: 32 consecutive winc with reads stopped → waddr steps 0..31. wfull rises on the edge of the 32nd write. wfill=32. wptr=6'b110000 (Gray of 32).
3. Overflow: with the FIFO full, assert winc for 3 cycles → wclken=0, wbin unchanged, wovf=1 and held. Pulse wovf_clr → wovf=0 next edge. wovf_clr together with winc while full → wovf stays 1.
4. Drain release: read 1 entry while full → wfull stays 1 for ≥2 wclk after rptr_gray changes, then clears. One further write is accepted and wfull re-asserts.
5. Wrap: 100 interleaved writes and reads → waddr wraps 31→0. The MSB of wptr toggles at writes 32 and 64. Every datum read matches the write order. wfull never rises while wfill<32.
6. WPTR_AFULL_EN, AFULL_LEVEL=28 → wafull=0 at wfill=27 and 1 at wfill=28. Reset mid-fill (wfill=15) → all outputs 0 on the next edge.
